// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 multi-cycle controller.
// Optional JSR support is enabled by defining LC3_JSR_EN.
package lc3_pkg;

  typedef enum logic [3:0] {
    OpBr = 4'h0, OpAdd, OpLd, OpSt, OpJsr, OpAnd, OpLdr, OpStr,
    OpRti, OpNot, OpLdi, OpSti, OpJmp, OpRes, OpLea, OpTrap
  } opcode_e;

  typedef enum logic [4:0] {
    StFetch0, StFetch1, StFetch2, StDecode, StAluEx, StBrEx, StJmpEx, StLeaEx,
    StAddr, StMemRd, StMemWb, StIndRd, StIndLd, StStData, StMemWr, StJsrSave, StJsrJmp
  } state_e;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluAnd  = 2'b01;
  localparam logic [1:0] AluNot  = 2'b10;
  localparam logic [1:0] AluPass = 2'b11;

  localparam logic [1:0] PcInc = 2'b00;
  localparam logic [1:0] PcEab = 2'b01;
  localparam logic [1:0] PcBus = 2'b10;

  localparam logic [1:0] Eab2Zero  = 2'b00;
  localparam logic [1:0] Eab2Off6  = 2'b01;
  localparam logic [1:0] Eab2Off9  = 2'b10;
  localparam logic [1:0] Eab2Off11 = 2'b11;

  typedef struct packed {
    logic       mem_en;
    logic       mem_we;
    logic       ena_alu;
    logic       ena_marm;
    logic       ena_pc;
    logic       ena_mdr;
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_mar;
    logic       ld_mdr;
    logic       reg_we;
    logic       flag_we;
    logic       sel_eab1;
    logic       sel_mar;
    logic       sel_mdr;
    logic [1:0] sel_pc;
    logic [1:0] sel_eab2;
    logic [1:0] alu_control;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_illegal(input opcode_e op);
    case (op)
      OpRti, OpTrap, OpRes: return 1'b1;
`ifndef LC3_JSR_EN
      OpJsr:                return 1'b1;
`endif
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ctrl_outputs.sv
// Combinational decode of controller state, IR and flags into the datapath control bundle.
module lc3_ctrl_outputs
  import lc3_pkg::*;
(
  input  logic        active_i,
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  input  logic        n_i,
  input  logic        z_i,
  input  logic        p_i,
  input  logic        mem_rdy_i,
  output ctrl_t       ctrl_o
);

  opcode_e op;
  logic    br_taken;
  logic    unused_ir_bits;

  assign op             = opcode_e'(ir_i[15:12]);
  assign br_taken       = (ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i);
  assign unused_ir_bits = ^ir_i[5:3];

  always_comb begin
    ctrl_o = '0;
    if (active_i) begin
      ctrl_o.sr1 = ir_i[8:6];
      ctrl_o.sr2 = ir_i[2:0];
      ctrl_o.dr  = ir_i[11:9];
      unique case (state_i)
        StFetch0: begin
          ctrl_o.ena_pc = 1'b1;
          ctrl_o.ld_mar = 1'b1;
          ctrl_o.ld_pc  = 1'b1;
          ctrl_o.sel_pc = PcInc;
        end
        StFetch1, StIndRd, StMemRd: begin
          ctrl_o.mem_en  = 1'b1;
          ctrl_o.sel_mdr = 1'b1;
          ctrl_o.ld_mdr  = mem_rdy_i;
        end
        StFetch2: begin
          ctrl_o.ena_mdr = 1'b1;
          ctrl_o.ld_ir   = 1'b1;
        end
        StDecode: ctrl_o.illegal = op_illegal(op);
        StAluEx: begin
          ctrl_o.ena_alu = 1'b1;
          ctrl_o.reg_we  = 1'b1;
          ctrl_o.flag_we = 1'b1;
          case (op)
            OpAnd:   ctrl_o.alu_control = AluAnd;
            OpNot:   ctrl_o.alu_control = AluNot;
            default: ctrl_o.alu_control = AluAdd;
          endcase
        end
        StBrEx: begin
          if (br_taken) begin
            ctrl_o.ld_pc    = 1'b1;
            ctrl_o.sel_pc   = PcEab;
            ctrl_o.sel_eab1 = 1'b0;
            ctrl_o.sel_eab2 = Eab2Off9;
          end
        end
        StJmpEx: begin
          ctrl_o.sel_eab1 = 1'b1;
          ctrl_o.sel_eab2 = Eab2Zero;
          ctrl_o.sel_pc   = PcEab;
          ctrl_o.ld_pc    = 1'b1;
        end
        StLeaEx: begin
          ctrl_o.sel_eab2 = Eab2Off9;
          ctrl_o.ena_marm = 1'b1;
          ctrl_o.reg_we   = 1'b1;
          ctrl_o.flag_we  = 1'b1;
        end
        StAddr: begin
          ctrl_o.ena_marm = 1'b1;
          ctrl_o.ld_mar   = 1'b1;
          if (op == OpLdr || op == OpStr) begin
            ctrl_o.sel_eab1 = 1'b1;
            ctrl_o.sel_eab2 = Eab2Off6;
          end else begin
            ctrl_o.sel_eab2 = Eab2Off9;
          end
        end
        StMemWb: begin
          ctrl_o.ena_mdr = 1'b1;
          ctrl_o.reg_we  = 1'b1;
          ctrl_o.flag_we = 1'b1;
        end
        StIndLd: begin
          // Pointer comes off the bus from MDR, not from the EAB adder.
          ctrl_o.ena_mdr = 1'b1;
          ctrl_o.ld_mar  = 1'b1;
          ctrl_o.sel_mar = 1'b1;
        end
        StStData: begin
          ctrl_o.sr1         = ir_i[11:9];
          ctrl_o.alu_control = AluPass;
          ctrl_o.ena_alu     = 1'b1;
          ctrl_o.sel_mdr     = 1'b0;
          ctrl_o.ld_mdr      = 1'b1;
        end
        StMemWr: begin
          ctrl_o.mem_en = 1'b1;
          ctrl_o.mem_we = 1'b1;
        end
        StJsrSave: begin
          ctrl_o.ena_pc = 1'b1;
          ctrl_o.dr     = 3'd7;
          ctrl_o.reg_we = 1'b1;
        end
        StJsrJmp: begin
          ctrl_o.ld_pc  = 1'b1;
          ctrl_o.sel_pc = PcEab;
          if (ir_i[11]) begin
            ctrl_o.sel_eab2 = Eab2Off11;
          end else begin
            ctrl_o.sel_eab1 = 1'b1;
            ctrl_o.sel_eab2 = Eab2Zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lc3_controller.sv
// LC-3 multi-cycle control unit: state register and next-state logic.
// Define LC3_JSR_EN to support JSR/JSRR (opcode 0100); otherwise it decodes as illegal.
module lc3_controller
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        mem_rdy,
  output logic        memEN,
  output logic        memWE,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic        selEAB1,
  output logic        selMAR,
  output logic        selMDR,
  output logic [1:0]  selPC,
  output logic [1:0]  selEAB2,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        illegal
);

  state_e  state_q, state_d;
  opcode_e op;
  ctrl_t   ctrl;

  assign op = opcode_e'(IR[15:12]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StFetch0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch0: state_d = StFetch1;
      StFetch1: if (mem_rdy) state_d = StFetch2;
      StFetch2: state_d = StDecode;
      StDecode: begin
        case (op)
          OpAdd, OpAnd, OpNot:                    state_d = StAluEx;
          OpBr:                                   state_d = StBrEx;
          OpJmp:                                  state_d = StJmpEx;
          OpLea:                                  state_d = StLeaEx;
          OpLd, OpLdr, OpLdi, OpSt, OpStr, OpSti: state_d = StAddr;
`ifdef LC3_JSR_EN
          OpJsr:                                  state_d = StJsrSave;
`endif
          default:                                state_d = StFetch0;
        endcase
      end
      StAddr: begin
        case (op)
          OpLdi, OpSti: state_d = StIndRd;
          OpSt, OpStr:  state_d = StStData;
          default:      state_d = StMemRd;
        endcase
      end
      StIndRd:   if (mem_rdy) state_d = StIndLd;
      StIndLd:   state_d = (op == OpSti) ? StStData : StMemRd;
      StMemRd:   if (mem_rdy) state_d = StMemWb;
      StStData:  state_d = StMemWr;
      StMemWr:   if (mem_rdy) state_d = StFetch0;
      StJsrSave: state_d = StJsrJmp;
      default:   state_d = StFetch0;
    endcase
  end

  lc3_ctrl_outputs u_outputs (
    .active_i  (rst),
    .state_i   (state_q),
    .ir_i      (IR),
    .n_i       (N),
    .z_i       (Z),
    .p_i       (P),
    .mem_rdy_i (mem_rdy),
    .ctrl_o    (ctrl)
  );

  assign memEN      = ctrl.mem_en;
  assign memWE      = ctrl.mem_we;
  assign enaALU     = ctrl.ena_alu;
  assign enaMARM    = ctrl.ena_marm;
  assign enaPC      = ctrl.ena_pc;
  assign enaMDR     = ctrl.ena_mdr;
  assign ldPC       = ctrl.ld_pc;
  assign ldIR       = ctrl.ld_ir;
  assign ldMAR      = ctrl.ld_mar;
  assign ldMDR      = ctrl.ld_mdr;
  assign regWE      = ctrl.reg_we;
  assign flagWE     = ctrl.flag_we;
  assign selEAB1    = ctrl.sel_eab1;
  assign selMAR     = ctrl.sel_mar;
  assign selMDR     = ctrl.sel_mdr;
  assign selPC      = ctrl.sel_pc;
  assign selEAB2    = ctrl.sel_eab2;
  assign aluControl = ctrl.alu_control;
  assign SR1        = ctrl.sr1;
  assign SR2        = ctrl.sr2;
  assign DR         = ctrl.dr;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_lc3_controller.sv
// Directed self-checking bench for lc3_controller.
module tb_lc3_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic        N, Z, P, mem_rdy;
  logic        memEN, memWE, enaALU, enaMARM, enaPC, enaMDR;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
  logic        selEAB1, selMAR, selMDR;
  logic [1:0]  selPC, selEAB2, aluControl;
  logic [2:0]  SR1, SR2, DR;
  logic        illegal;
  logic [30:0] all_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lc3_controller dut (
    .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .mem_rdy(mem_rdy),
    .memEN(memEN), .memWE(memWE), .enaALU(enaALU), .enaMARM(enaMARM), .enaPC(enaPC),
    .enaMDR(enaMDR), .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .regWE(regWE), .flagWE(flagWE), .selEAB1(selEAB1), .selMAR(selMAR), .selMDR(selMDR),
    .selPC(selPC), .selEAB2(selEAB2), .aluControl(aluControl), .SR1(SR1), .SR2(SR2),
    .DR(DR), .illegal(illegal)
  );

  assign all_out = {memEN, memWE, enaALU, enaMARM, enaPC, enaMDR, ldPC, ldIR, ldMAR, ldMDR,
                    regWE, flagWE, selEAB1, selMAR, selMDR, selPC, selEAB2, aluControl,
                    SR1, SR2, DR, illegal};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH0 until FETCH0 comes round again.
  // Each memory access is stretched by 'waits' cycles of mem_rdy low.
  task automatic run_instr(input logic [15:0] ir, input int waits, output int cycles,
                           output int n_mem, output int n_wb, output int n_ill);
    int wcnt = 0;
    IR = ir;
    cycles = 0; n_mem = 0; n_wb = 0; n_ill = 0;
    for (int guard = 0; guard < 80; guard++) begin
      if (memEN) begin
        if (wcnt < waits) begin
          mem_rdy = 1'b0;
          wcnt++;
        end else begin
          mem_rdy = 1'b1;
          wcnt = 0;
        end
      end else begin
        mem_rdy = 1'b1;
      end
      #1;
      cycles++;
      if (memEN) n_mem++;
      if (regWE && enaMDR) n_wb++;
      if (illegal) n_ill++;
      tick();
      if (enaPC && ldMAR) break;
    end
    mem_rdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, nm, nw, ni;
    rst = 1'b0; IR = 16'h1042; N = 1'b0; Z = 1'b0; P = 1'b0; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_val("reset_outputs_zero", all_out, 0);

    // ADD R0,R1,R2
    @(negedge clk); rst = 1'b1; #1;
    check_val("add_fetch0", {enaPC, ldMAR, ldPC, selPC}, 5'b11100);
    tick(); check_val("add_fetch1", {memEN, selMDR, ldMDR}, 3'b111);
    tick(); check_val("add_fetch2", {enaMDR, ldIR}, 2'b11);
    tick(); check_val("add_decode_illegal", illegal, 0);
    tick(); check_val("add_alu_ex", {enaALU, regWE, flagWE, DR, SR1, SR2, aluControl},
                      {3'b111, 3'd0, 3'd1, 3'd2, 2'b00});
    tick(); check_val("add_back_fetch0", {enaPC, ldMAR}, 2'b11);

    // BRnp with Z: not taken; with N: taken
    IR = 16'h0A05; Z = 1'b1;
    repeat (4) tick();
    check_val("brnp_z_ldpc", ldPC, 0);
    tick();
    N = 1'b1; Z = 1'b0;
    repeat (4) tick();
    check_val("brnp_n_taken", {ldPC, selPC, selEAB2, selEAB1}, {1'b1, 2'b01, 2'b10, 1'b0});
    tick();
    N = 1'b0;

    // LDI with two wait cycles on every read
    run_instr(16'hA003, 2, cyc, nm, nw, ni);
    check_val("ldi_wait_cycles", cyc, 15);
    check_val("ldi_memen_cycles", nm, 9);
    check_val("ldi_writeback", nw, 1);

    run_instr(16'h2003, 0, cyc, nm, nw, ni); check_val("ld_cycles", cyc, 7);
    run_instr(16'h6042, 0, cyc, nm, nw, ni); check_val("ldr_cycles", cyc, 7);
    run_instr(16'h3003, 0, cyc, nm, nw, ni); check_val("st_cycles", cyc, 7);
    run_instr(16'hB003, 0, cyc, nm, nw, ni); check_val("sti_cycles", cyc, 9);
    run_instr(16'hE003, 0, cyc, nm, nw, ni); check_val("lea_cycles", cyc, 5);
    run_instr(16'hC080, 0, cyc, nm, nw, ni); check_val("jmp_cycles", cyc, 5);
    run_instr(16'h5042, 0, cyc, nm, nw, ni); check_val("and_cycles", cyc, 5);

    // STR R2,R1,#2 with one wait in MEM_WR
    IR = 16'h7442;
    repeat (4) tick();
    check_val("str_addr", {enaMARM, ldMAR, selEAB1, selEAB2}, 5'b11101);
    tick();
    check_val("str_st_data", {SR1, aluControl, selMDR, ldMDR, enaALU}, {3'd2, 2'b11, 3'b011});
    mem_rdy = 1'b0;
    tick(); check_val("str_mem_wr_wait", {memEN, memWE}, 2'b11);
    tick(); check_val("str_mem_wr_hold", {memEN, memWE}, 2'b11);
    mem_rdy = 1'b1;
    tick(); check_val("str_back_fetch0", {enaPC, ldMAR, memEN}, 3'b110);

    // Illegal opcodes
    run_instr(16'h8000, 0, cyc, nm, nw, ni);
    check_val("rti_cycles", cyc, 4);
    check_val("rti_illegal_pulses", ni, 1);
    check_val("rti_next_fetch0", {enaPC, illegal}, 2'b10);
    run_instr(16'hD000, 0, cyc, nm, nw, ni);
    check_val("reserved_illegal_pulses", ni, 1);
    run_instr(16'h4803, 0, cyc, nm, nw, ni);
`ifdef LC3_JSR_EN
    check_val("jsr_cycles", cyc, 6);
    check_val("jsr_illegal", ni, 0);
`else
    check_val("jsr_cycles", cyc, 4);
    check_val("jsr_illegal", ni, 1);
`endif

    // Reset asserted during MEM_RD
    IR = 16'h2003; mem_rdy = 1'b1;
    repeat (5) tick();
    mem_rdy = 1'b0; #1;
    check_val("mem_rd_before_reset", {memEN, ldMDR}, 2'b10);
    #1 rst = 1'b0;
    #1 check_val("mid_reset_zero", all_out, 0);
    tick(); check_val("held_reset_zero", all_out, 0);
    mem_rdy = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    check_val("post_reset_fetch0", {enaPC, ldMAR, memEN}, 3'b110);
    tick(); check_val("post_reset_fetch1", memEN, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
# lc3_controller

Multi-cycle LC-3 control unit sitting directly upstream of the LC-3 datapath. It sequences fetch, decode and execute for every instruction. It drives every datapath control strobe, mux select and register-field select. It runs the memory read/write handshake. It consumes only IR and the N/Z/P flags fed back from the datapath.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- IR  in  16  instruction register from datapath
- N, Z, P  in  1 each  condition flags from datapath
- mem_rdy  in  1  memory completes current access this cycle
- memEN, memWE  out  1  memory access request / write qualifier
- enaALU, enaMARM, enaPC, enaMDR  out  1  bus tri-state enables, at most one high
- ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE  out  1  register loads
- selEAB1, selMAR, selMDR  out  1  selects: EAB1 0=PC/1=SR1; MAR 0=EAB; MDR 1=memory/0=bus
- selPC, selEAB2, aluControl  out  2  PC 00=PC+1/01=EAB/10=bus; EAB2 00=0/01=off6/10=off9/11=off11; ALU 00=ADD/01=AND/10=NOT/11=PASS
- SR1, SR2, DR  out  3  register-file addresses
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- State register only; all outputs decoded combinationally from state, IR and flags.
- All outputs forced to 0 while rst==0.
- Fetch sequence:
  - FETCH0: enaPC, ldMAR, ldPC, selPC=00.
  - FETCH1: memEN, selMDR=1, ldMDR=mem_rdy; held until mem_rdy.
  - FETCH2: enaMDR, ldIR.
  - DECODE: branches on IR[15:12].
- Default field selects: SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9].
- ADD/AND/NOT → ALU_EX:
  - enaALU, regWE, flagWE; aluControl from opcode.
  - NOT forces aluControl=10.
- BR → BR_EX: ldPC, selPC=01, selEAB1=0, selEAB2=10, only if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P). nzp=000 is never taken.
- JMP → JMP_EX: selEAB1=1, selEAB2=00, selPC=01, ldPC.
- LEA → LEA_EX: selEAB1=0, selEAB2=10, enaMARM, regWE, flagWE.
- LD/LDR/LDI/ST/STR/STI → ADDR: enaMARM, ldMAR.
  - LD/LDI/ST/STI use PC+off9.
  - LDR/STR use SR1+off6.
- LD/LDR: ADDR → MEM_RD (memEN until mem_rdy, ldMDR) → MEM_WB (enaMDR, regWE, flagWE).
- LDI: ADDR → IND_RD (read like MEM_RD) → IND_LD (enaMDR, ldMAR) → MEM_RD → MEM_WB.
- ST/STR: ADDR → ST_DATA (SR1=IR[11:9], aluControl=11, enaALU, selMDR=0, ldMDR) → MEM_WR (memEN, memWE until mem_rdy).
- STI: IND_RD/IND_LD pair inserted before ST_DATA.
- Every terminal execute state returns to FETCH0.
- RTI, TRAP, reserved (1101), and JSR when disabled: pulse illegal in DECODE, then return to FETCH0 as a NOP.

## Timing
- Zero-wait memory (mem_rdy high in first request cycle); total cycles including fetch:
  - ALU, LEA, BR, JMP: 5.
  - LD/LDR: 7.
  - ST/STR: 7.
  - LDI: 9.
  - STI: 9.
- Each wait cycle on mem_rdy extends the owning state by exactly one cycle. memEN is held stable throughout.
- Flags are sampled combinationally in BR_EX, the cycle after DECODE.
- rst asserted mid-instruction: state goes to FETCH0 immediately, outputs go to 0. The first fetch starts on the first edge after release.

## Configuration
- LC3_JSR_EN defined: opcode 0100 supported.
  - JSR_SAVE: enaPC, DR=7, regWE, no flagWE.
  - JSR_JMP: ldPC, selPC=01.
    - IR[11]=1: selEAB1=0, selEAB2=11.
    - IR[11]=0: selEAB1=1, selEAB2=00, SR1=IR[8:6].
  - Total 6 cycles.
- LC3_JSR_EN undefined: 0100 is illegal, treated as a NOP.

## Structure
- Shared package lc3_pkg holds:
  - opcode enum;
  - state enum;
  - aluControl, selPC and selEAB2 encoding constants.
- One sub-module, lc3_ctrl_outputs: a purely combinational map of (state, IR, N/Z/P) to the control bundle. The top holds the state register and next-state logic.

## Test plan
- Reset release, mem_rdy=1, IR=0x1042 (ADD R0,R1,R2): FETCH0 enaPC+ldMAR; ALU_EX on cycle 5 with regWE, flagWE, DR=0, SR1=1, SR2=2, aluControl=00.
- IR=0x0A05 (BRnp) with Z=1 → no ldPC in BR_EX; with N=1 → ldPC, selPC=01, selEAB2=10.
- IR=0xA003 (LDI R0), mem_rdy held low 2 cycles in each read → 15 cycles total; memEN continuous during waits; final regWE with enaMDR.
- IR=0x7442 (STR R2,R1,#2) → ST_DATA SR1=2, aluControl=11, selMDR=0; MEM_WR memEN & memWE until mem_rdy.
- IR=0x8000 (RTI) → illegal pulses exactly one cycle; next cycle FETCH0.
- rst driven low during MEM_RD → all outputs 0 asynchronously; after release, FETCH0 asserts enaPC.
